// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - requester/link bundle between crossbar inputs, output port arbiter and link
interface output_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 5
);
    logic [N-1:0]            req;
    logic [N-1:0]            last;
    logic [N*DATA_WIDTH-1:0] Data_in;
    logic                    ret;
    logic [N-1:0]            gnt;
    logic [DATA_WIDTH-1:0]   Data_out;
    logic                    val;
    logic                    busy;

    modport slave (
        input  req,
        input  last,
        input  Data_in,
        input  ret,
        output gnt,
        output Data_out,
        output val,
        output busy
    );

    modport master (
        output req,
        output last,
        output Data_in,
        output ret,
        input  gnt,
        input  Data_out,
        input  val,
        input  busy
    );
endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - wormhole round-robin output port arbiter; optional idle-owner timeout via OUTPUT_PORT_ARB_TIMEOUT_EN
module output_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 5,
    parameter int PTR_W      = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    output_port_arbiter_if.slave   port_if
);
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      pick;
    logic [PTR_W-1:0]      owner_succ;
    logic                  found;
    int                    idx;
    logic                  owner_req;
    logic                  owner_last;
    logic                  accept;
    logic                  timeout_hit;
    logic                  release_lock;
    logic [DATA_WIDTH-1:0] flits [N];
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  val_q;
    logic                  busy_q;

    for (genvar i = 0; i < N; i++) begin : g_flit
        assign flits[i] = port_if.Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign owner_req    = port_if.req[owner];
    assign owner_last   = port_if.last[owner];
    assign accept       = (state == LOCKED) && owner_req && !port_if.ret;
    assign release_lock = (accept && owner_last) || timeout_hit;
    assign owner_succ   = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;

    // Rotating search: first requester at or after ptr, wrapping modulo N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && port_if.req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

`ifdef OUTPUT_PORT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == LOCKED) && !owner_req
                         && (idle_cnt == CNT_W'(TIMEOUT - 1));

    // Only cycles where the owner has nothing to offer count; ret stalls do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != LOCKED || owner_req || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                owner <= pick;
            end
            if (release_lock) begin
                ptr <= owner_succ;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found)        state_next = LOCKED;
            LOCKED:  if (release_lock) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        port_if.gnt = '0;
        if (!rst && accept) begin
            port_if.gnt[owner] = 1'b1;
        end
    end

    // The link is zeroed on every non-accept cycle so it never repeats a flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            val_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            dout_q <= accept ? flits[owner] : '0;
            val_q  <= accept;
            busy_q <= (state_next == LOCKED);
        end
    end

    assign port_if.Data_out = dout_q;
    assign port_if.val      = val_q;
    assign port_if.busy     = busy_q;
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Shares one router output port among N input-side requesters using wormhole switching and round-robin fairness.
- Sits between the crossbar inputs and the output stage.
- Locks the port to one requester from head flit to tail flit.
- Stalls on the neighbour router's full signal (ret) and drives a registered flit plus a valid strobe to the link.

Parameters:
- DATA_WIDTH, 8, flit width in bits.
- N, 5, number of requesters (Local, North, East, South, West); index 0 = Local.
- PTR_W, 3, width of the round-robin pointer and owner index; must satisfy 2^PTR_W >= N.
- TIMEOUT, 15, idle-owner cycle limit; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  req[i]=1: requester i presents a valid flit on its Data_in slice.
- last  input  N  last[i]=1: the flit from requester i is a tail flit; meaningful only when req[i]=1.
- Data_in  input  N*DATA_WIDTH  flit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ret  input  1  full from the neighbour router; 1 = no flit may be sent this cycle.
- gnt  output  N  combinational one-hot accept; gnt[i]=1 means requester i's flit is consumed at this edge.
- Data_out  output  DATA_WIDTH  registered outgoing flit.
- val  output  1  registered; 1 when Data_out holds a flit sent this cycle.
- busy  output  1  registered; 1 while the port is locked (state LOCKED).

Behaviour:
- Reset (async, any time, including mid-packet):
  - state=IDLE, ptr=0, owner=0, Data_out=0, val=0, busy=0; gnt=0 while rst is high.
  - Any partially sent packet is abandoned and no further flits of it are forwarded.
- States:
  - IDLE: no owner. If any req bit is 1, select the first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
    - Register owner=i; state goes to LOCKED at the next edge. No flit is accepted in IDLE (one-cycle arbitration bubble). busy=1 from that edge.
  - LOCKED: only the owner is served.
    - Accept condition: req[owner]=1 and ret=0. gnt[owner]=1 combinationally; all other gnt bits are 0.
    - On accept, at the next edge: Data_out=Data_in slice of owner, val=1.
    - If last[owner]=1 on accept: state goes to IDLE, ptr=(owner+1) mod N, busy=0 at the same edge.
    - If the owner drops req mid-packet, or ret=1: hold the lock with no accept; Data_out=0, val=0 that cycle.
- On every cycle without an accept: Data_out=0, val=0. The link never carries a stale flit.
- Latency:
  - First flit: req rises at cycle t; gnt at t+1; Data_out valid at t+2.
  - Subsequent flits: gnt to Data_out is 1 cycle; up to one flit per cycle when ret=0.
- Single-flit packets (req with last=1 on the head): accepted once; the port returns to IDLE. Each single-flit packet therefore costs 2 cycles.
- Simultaneous tail accept and new requests: the next arbitration happens in the IDLE cycle that follows, using the updated ptr. There is no back-to-back grant in the same cycle.
- Wrap-around: if owner=N-1, ptr becomes 0.
- Requests from non-owners are ignored while LOCKED; gnt for them stays 0.
- A ret change takes effect in the same cycle (combinational into gnt).
- Flit contents are never inspected. Zero-valued flits are forwarded when accepted.

Optional Feature:
- Macro: OUTPUT_PORT_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) counts consecutive LOCKED cycles with req[owner]=0. ret stalls do not count; the counter is cleared by any accept or by req[owner]=1.
  - When the count reaches TIMEOUT: state goes to IDLE, ptr=(owner+1) mod N, busy=0, and the lock is released without a tail.
  - The counter resets to 0 on rst.
- Not defined: no counter is built, and the lock holds indefinitely until the tail flit.

Test Plan:
- Single requester, single flit: req=5'b00010, last=5'b00010, flit1=8'hA5, ret=0 -> gnt[1]=1 at cycle 1; Data_out=8'hA5, val=1 at cycle 2; busy=0 after; ptr=2.
- Wormhole lock: requester 0 sends 3 flits (8'h11, 8'h22, 8'h33; last on third) while requester 3 holds req=1 -> gnt[3] stays 0 until 8'h33 is out; then requester 3 is granted after one IDLE cycle.
- Round-robin fairness: req=5'b11111 continuously, all single-flit -> grant order 0,1,2,3,4,0; ptr wraps from 4 to 0.
- Back-pressure: mid-packet, ret=1 for 3 cycles -> gnt=0, val=0, Data_out=0 during the stall; the flit held by the owner emerges one cycle after ret falls; no flit is lost or duplicated.
- Reset mid-packet: assert rst after the 2nd of 4 flits -> Data_out=0, val=0, busy=0 immediately; after release, ptr=0 and a new arbitration starts from index 0.
- Timeout (macro defined, TIMEOUT=4): owner 2 drops req mid-packet for 4 cycles -> busy falls at the 4th idle cycle; ptr=3; requester 3 is granted next. With the macro undefined, busy stays 1.
